// File: rtl/core_isa_pkg.sv
// Shared ISA definitions: opcode table, instruction field layout and the
// retirement-checker state encoding used by core decode and the checker.
package core_isa_pkg;

   localparam int NUM_REGS_DEF = 8;

   localparam logic [7:0] ALU_NO_OP   = 8'd0;
   localparam logic [7:0] ALU_ADD_REG = 8'd1;
   localparam logic [7:0] ALU_ADD_IMM = 8'd2;
   localparam logic [7:0] ALU_MUL_REG = 8'd3;
   localparam logic [7:0] ALU_MUL_IMM = 8'd4;

   typedef struct packed {
      logic [7:0] op;
      logic [7:0] res;
      logic [7:0] op1;
      logic [7:0] op2;
   } instr_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_ERROR = 2'd2
   } checker_state_e;

   // op2 is a register index only for the register-register forms
   function automatic logic op2_is_reg(logic [7:0] op);
      return (op == ALU_ADD_REG) || (op == ALU_MUL_REG);
   endfunction

endpackage

// File: rtl/retire_golden_alu.sv
// Architectural reference ALU: (op, a, b_reg, imm) -> {result, legal}.
// Ports: op, a, b_reg, imm in; result, legal out. Purely combinational.
module retire_golden_alu
   import core_isa_pkg::*;
(
   input  logic [7:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b_reg,
   input  logic [7:0]  imm,
   output logic [31:0] result,
   output logic        legal
);

   logic [31:0] imm_ext;

   assign imm_ext = {24'b0, imm};

   // Results keep the low 32 bits; products wrap.
   always_comb begin
      result = '0;
      legal  = 1'b1;
      unique case (1'b1)
         op == ALU_ADD_REG: result = a + b_reg;
         op == ALU_ADD_IMM: result = a + imm_ext;
         op == ALU_MUL_REG: result = a * b_reg;
         op == ALU_MUL_IMM: result = a * imm_ext;
         default:           legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/retire_checker.sv
// Golden-model checker on the core retirement port: shadow regfile, re-execution,
// first-divergence capture and retirement watchdog.
// Ports: clock_i, reset_i (sync, active high), enable_i, retire_i, retire_instr_i,
//   regfile_i in; mismatch_o, mismatch_instr_o, mismatch_reg_o, expected_o,
//   actual_o, hang_o, retired_count_o, state_o out.
module retire_checker
   import core_isa_pkg::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEF,
   parameter int COUNT_W  = 32,
   parameter int TIMEOUT  = 1024
) (
   input  logic                     clock_i,
   input  logic                     reset_i,
   input  logic                     enable_i,
   input  logic                     retire_i,
   input  logic [31:0]              retire_instr_i,
   input  logic [NUM_REGS-1:0][31:0] regfile_i,
   output logic                     mismatch_o,
   output logic [31:0]              mismatch_instr_o,
   output logic [2:0]               mismatch_reg_o,
   output logic [31:0]              expected_o,
   output logic [31:0]              actual_o,
   output logic                     hang_o,
   output logic [COUNT_W-1:0]       retired_count_o,
   output logic [1:0]               state_o
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   typedef logic [NUM_REGS-1:0][31:0] rf_t;

   checker_state_e state_q, state_d;

   rf_t              shadow_q;
   rf_t              expected_rf;
   logic [31:0]      wd_q;
   logic [31:0]      wd_inc;
   logic [COUNT_W-1:0] count_q;

   instr_t           ins;
   logic [IDX_W-1:0] res_idx, op1_idx, op2_idx;
   logic             idx_ok, alu_legal, checked;
   logic [31:0]      alu_a, alu_b, alu_res;

   logic             any_diff;
   logic [2:0]       diff_idx;
   logic [31:0]      diff_exp, diff_act;
   logic             in_run, mism_ev, hang_ev;

   // Mux-based read so an out-of-range index yields 0, never X.
   function automatic logic [31:0] rd(rf_t rf, logic [IDX_W-1:0] idx);
      rd = '0;
      for (int i = 0; i < NUM_REGS; i++)
         if (idx == IDX_W'(i)) rd = rf[i];
   endfunction

   assign ins     = instr_t'(retire_instr_i);
   assign res_idx = ins.res[IDX_W-1:0];
   assign op1_idx = ins.op1[IDX_W-1:0];
   assign op2_idx = ins.op2[IDX_W-1:0];

   // Only the fields an opcode actually uses must be in range.
   assign idx_ok = ({24'b0, ins.res} < 32'(NUM_REGS))
                && ({24'b0, ins.op1} < 32'(NUM_REGS))
                && (!op2_is_reg(ins.op) || ({24'b0, ins.op2} < 32'(NUM_REGS)));

   assign alu_a = rd(shadow_q, op1_idx);
   assign alu_b = rd(shadow_q, op2_idx);

   retire_golden_alu u_alu (
      .op     (ins.op),
      .a      (alu_a),
      .b_reg  (alu_b),
      .imm    (ins.op2),
      .result (alu_res),
      .legal  (alu_legal)
   );

   assign checked = alu_legal && idx_ok;

   always_comb begin
      expected_rf = shadow_q;
      for (int i = 0; i < NUM_REGS; i++)
         if (res_idx == IDX_W'(i)) expected_rf[i] = alu_res;
   end

   // Descending scan: the lowest differing index is written last and wins.
   always_comb begin
      any_diff = 1'b0;
      diff_idx = '0;
      diff_exp = '0;
      diff_act = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (expected_rf[i] != regfile_i[i]) begin
            any_diff = 1'b1;
            diff_idx = 3'(i);
            diff_exp = expected_rf[i];
            diff_act = regfile_i[i];
         end
      end
   end

   assign in_run  = (state_q == ST_RUN);
   assign wd_inc  = wd_q + 32'd1;
   assign mism_ev = in_run && retire_i && checked && any_diff;
   assign hang_ev = in_run && !retire_i && (TIMEOUT != 0)
                 && (wd_inc == 32'(TIMEOUT));

   always_ff @(posedge clock_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (enable_i) state_d = ST_RUN;
         ST_RUN: begin
            if (mism_ev || hang_ev) state_d = ST_ERROR;
            else if (!enable_i)     state_d = ST_IDLE;
         end
         ST_ERROR: state_d = ST_ERROR;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         shadow_q         <= '0;
         wd_q             <= '0;
         count_q          <= '0;
         mismatch_o       <= 1'b0;
         mismatch_instr_o <= '0;
         mismatch_reg_o   <= '0;
         expected_o       <= '0;
         actual_o         <= '0;
         hang_o           <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               shadow_q <= regfile_i;
               wd_q     <= '0;
            end
            ST_RUN: begin
               if (retire_i) begin
                  wd_q <= '0;
                  if (!checked) begin
                     shadow_q <= regfile_i;
                     count_q  <= count_q + 1'b1;
                  end else if (!any_diff) begin
                     shadow_q <= expected_rf;
                     count_q  <= count_q + 1'b1;
                  end else begin
                     mismatch_o       <= 1'b1;
                     mismatch_instr_o <= retire_instr_i;
                     mismatch_reg_o   <= diff_idx;
                     expected_o       <= diff_exp;
                     actual_o         <= diff_act;
                  end
               end else begin
                  wd_q <= wd_inc;
                  if (hang_ev) hang_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign retired_count_o = count_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_retire_checker.sv
// Directed bench for retire_checker: scoreboard of per-retire expectations,
// immediate-assertion checks, watchdog and sticky-error scenarios.
module tb_retire_checker;

   logic             clk = 1'b0;
   logic             reset, enable, retire;
   logic [31:0]      instr;
   logic [7:0][31:0] rf;
   logic             mis, hang;
   logic [31:0]      mis_instr, exp_v, act_v, count;
   logic [2:0]       mis_reg;
   logic [1:0]       state;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        mis;
      logic [1:0]  st;
      logic [31:0] cnt;
      logic [2:0]  rg;
      logic [31:0] ev;
      logic [31:0] av;
   } exp_t;

   exp_t  sbq[$];
   string tagq[$];

   retire_checker #(.NUM_REGS(8), .COUNT_W(32), .TIMEOUT(16)) dut (
      .clock_i          (clk),
      .reset_i          (reset),
      .enable_i         (enable),
      .retire_i         (retire),
      .retire_instr_i   (instr),
      .regfile_i        (rf),
      .mismatch_o       (mis),
      .mismatch_instr_o (mis_instr),
      .mismatch_reg_o   (mis_reg),
      .expected_o       (exp_v),
      .actual_o         (act_v),
      .hang_o           (hang),
      .retired_count_o  (count),
      .state_o          (state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exv);
      checks++;
      assert (obs === exv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exv);
      end
   endtask

   function automatic exp_t mk(logic m, logic [1:0] s, logic [31:0] c,
                               logic [2:0] r, logic [31:0] e, logic [31:0] a);
      exp_t x;
      x.mis = m; x.st = s; x.cnt = c; x.rg = r; x.ev = e; x.av = a;
      return x;
   endfunction

   // Drive one retire with the current rf, push its expectation, then
   // pop and compare once the result is visible after the edge.
   task automatic do_retire(input string tag, input logic [31:0] ins, input exp_t e);
      exp_t  x;
      string t;
      instr  = ins;
      retire = 1'b1;
      sbq.push_back(e);
      tagq.push_back(tag);
      tick();
      retire = 1'b0;
      x = sbq.pop_front();
      t = tagq.pop_front();
      chk({t, "_mis"},   {31'b0, mis}, {31'b0, x.mis});
      chk({t, "_state"}, {30'b0, state}, {30'b0, x.st});
      chk({t, "_count"}, count, x.cnt);
      if (x.mis) begin
         chk({t, "_reg"},   {29'b0, mis_reg}, {29'b0, x.rg});
         chk({t, "_exp"},   exp_v, x.ev);
         chk({t, "_act"},   act_v, x.av);
         chk({t, "_instr"}, mis_instr, ins);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      enable = 1'b0;
      retire = 1'b0;
      instr  = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Reset, let IDLE resync the shadow to rf, then enter RUN.
   task automatic setup_run();
      do_reset();
      tick();
      enable = 1'b1;
      tick();
   endtask

   initial begin
      rf = '0;
      do_reset();
      chk("rst_state", {30'b0, state}, 32'd0);
      chk("rst_mis",   {31'b0, mis}, 32'd0);
      chk("rst_hang",  {31'b0, hang}, 32'd0);
      chk("rst_count", count, 32'd0);
      chk("rst_exp",   exp_v, 32'd0);
      chk("rst_act",   act_v, 32'd0);
      chk("rst_reg",   {29'b0, mis_reg}, 32'd0);

      rf = '0; rf[0] = 32'd5; rf[1] = 32'd7;
      tick();
      enable = 1'b1;
      tick();
      chk("enter_run", {30'b0, state}, 32'd1);

      rf[2] = 32'd12;
      do_retire("add_reg", 32'h01020001, mk(0, 1, 1, 0, 0, 0));

      rf[1] = 32'h3000_0000;
      do_retire("op7_resync", 32'h07000000, mk(0, 1, 2, 0, 0, 0));

      rf[3] = 32'h2000_0000;
      do_retire("mul_imm_wrap", 32'h04030106, mk(0, 1, 3, 0, 0, 0));

      rf[2] = 32'h0000_FFFF;
      do_retire("op1_illegal", 32'h01020900, mk(0, 1, 4, 0, 0, 0));

      rf[4] = 32'd7;
      enable = 1'b0;
      do_retire("dis_same_cyc", 32'h02040002, mk(0, 0, 5, 0, 0, 0));

      rf = '0; rf[1] = 32'h3000_0000;
      setup_run();
      rf[3] = 32'h0001_0000;
      do_retire("mul_mis", 32'h04030106,
                mk(1, 2, 0, 3, 32'h2000_0000, 32'h0001_0000));
      rf[3] = 32'h2000_0000;
      instr = 32'h04030106;
      retire = 1'b1;
      enable = 1'b0;
      tick();
      retire = 1'b0;
      chk("err_sticky_state", {30'b0, state}, 32'd2);
      chk("err_frozen_count", count, 32'd0);
      chk("err_frozen_act",   act_v, 32'h0001_0000);

      rf = '0; rf[0] = 32'd5; rf[1] = 32'd7;
      setup_run();
      rf[2] = 32'd12; rf[5] = 32'h0000_DEAD;
      do_retire("r5_corrupt", 32'h01020001, mk(1, 2, 0, 5, 0, 32'h0000_DEAD));

      rf = '0; rf[0] = 32'd5; rf[1] = 32'd7;
      setup_run();
      rf[2] = 32'd13; rf[5] = 32'h0000_DEAD;
      do_retire("r2_and_r5", 32'h01020001, mk(1, 2, 0, 2, 32'd12, 32'd13));

      rf = '0; rf[0] = 32'd5; rf[1] = 32'd7;
      setup_run();
      rf[2] = 32'd13;
      enable = 1'b0;
      do_retire("dis_mis", 32'h01020001, mk(1, 2, 0, 2, 32'd12, 32'd13));

      rf = '0;
      setup_run();
      repeat (15) tick();
      chk("wd_15_hang",  {31'b0, hang}, 32'd0);
      chk("wd_15_state", {30'b0, state}, 32'd1);
      tick();
      chk("wd_16_hang",  {31'b0, hang}, 32'd1);
      chk("wd_16_state", {30'b0, state}, 32'd2);
      do_reset();
      chk("clr_hang",  {31'b0, hang}, 32'd0);
      chk("clr_state", {30'b0, state}, 32'd0);
      chk("clr_mis",   {31'b0, mis}, 32'd0);

      rf = '0;
      setup_run();
      for (int i = 1; i <= 100; i++) begin
         rf[0] = 32'(i);
         do_retire("b2b_addi", 32'h02000001, mk(0, 1, 32'(i), 0, 0, 0));
      end
      chk("b2b_hang", {31'b0, hang}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
